// File: rtl/weight_drm_loader.sv
// Packs PACK_NUM consecutive IN_WIDTH-bit weight beats into one word per DRM write.
// Optional WEIGHT_LOADER_LANE_REVERSE_EN places the first beat of a word in the top lane.
module weight_drm_loader #(
  parameter int IN_WIDTH       = 36,
  parameter int PACK_NUM       = 9,
  parameter int DATA_OUT_WIDTH = 324,
  parameter int WR_ADDR_DEPTH  = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [WR_ADDR_DEPTH-1:0]  base_addr,
  input  logic [WR_ADDR_DEPTH:0]    load_len,
  input  logic [IN_WIDTH-1:0]       s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [DATA_OUT_WIDTH-1:0] WeightDRM_data_wr,
  output logic                      WeightDRM_valid_wr,
  output logic [WR_ADDR_DEPTH-1:0]  WeightDRM_addr_wr,
  output logic                      busy,
  output logic                      done
);

  localparam int LANE_W = $clog2(PACK_NUM);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_NUM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                    state;
  logic [LANE_W-1:0]         lane_cnt;
  logic [LANE_W-1:0]         lane_pos;
  logic [WR_ADDR_DEPTH:0]    word_cnt;
  logic [WR_ADDR_DEPTH:0]    len_q;
  logic [WR_ADDR_DEPTH-1:0]  base_q;
  logic [DATA_OUT_WIDTH-1:0] pack_p0;
  logic [DATA_OUT_WIDTH-1:0] word_nxt;
  logic                      accept;
  logic                      last_beat;

  assign accept    = s_valid & s_ready;
  assign last_beat = (lane_cnt == LAST_LANE);

`ifdef WEIGHT_LOADER_LANE_REVERSE_EN
  assign lane_pos = LAST_LANE - lane_cnt;
`else
  assign lane_pos = lane_cnt;
`endif

  // p0: lane packing register, overwritten lane by lane so it needs no clear
  always_ff @(posedge clk) begin
    if (accept)
      pack_p0[lane_pos*IN_WIDTH +: IN_WIDTH] <= s_data;
  end

  // Completed word = stored lanes plus the beat arriving this cycle
  always_comb begin
    word_nxt = pack_p0;
    word_nxt[lane_pos*IN_WIDTH +: IN_WIDTH] = s_data;
  end

  // p1: control FSM and DRM write register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= IDLE;
      s_ready            <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      lane_cnt           <= '0;
      word_cnt           <= '0;
      len_q              <= '0;
      base_q             <= '0;
      WeightDRM_valid_wr <= 1'b0;
      WeightDRM_addr_wr  <= '0;
      WeightDRM_data_wr  <= '0;
    end else begin
      WeightDRM_valid_wr <= 1'b0;
      done               <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (load_len != '0) begin
              base_q   <= base_addr;
              len_q    <= load_len;
              lane_cnt <= '0;
              word_cnt <= '0;
              s_ready  <= 1'b1;
              state    <= LOAD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (last_beat) begin
              lane_cnt           <= '0;
              word_cnt           <= word_cnt + 1'b1;
              WeightDRM_data_wr  <= word_nxt;
              WeightDRM_valid_wr <= 1'b1;
              WeightDRM_addr_wr  <= base_q + word_cnt[WR_ADDR_DEPTH-1:0];
              if (word_cnt + 1'b1 == len_q) begin
                s_ready <= 1'b0;
                done    <= 1'b1;
                state   <= DONE;
              end
            end else begin
              lane_cnt <= lane_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          s_ready <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
